// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with a set-2 decoder that tracks the W/S/O/L keys.
// Frames are accepted on the iCLK domain after 2-flop synchronisation of the bus lines.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w_in,
    output logic       s_in,
    output logic       o_in,
    output logic       l_in,
    output logic [7:0] oSCANCODE,
    output logic       oKEY_VALID,
    output logic       oFRAME_ERR
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic          fall;
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ok_q, ok_d, err_q, err_d;
    logic          brk_q, ext_q, w_q, s_q, o_q, l_q;
    logic [7:0]    sc_q;
    logic          kv_q, fe_q;

    assign fall = ~clk_s2_q & clk_prev_q;

    // Synchronisers reset to 1 so the idle bus never looks like an edge.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE || fall) tmo_d = '0;
        else                         tmo_d = tmo_q + 1'b1;
        case (state_q)
            IDLE: if (fall && !dat_s2_q) begin
                state_d = DATA;
                cnt_d   = 3'd0;
            end
            DATA: if (fall) begin
                shift_d = {dat_s2_q, shift_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                par_d   = dat_s2_q;
                state_d = STOP;
            end
            STOP: if (fall) begin
                state_d = IDLE;
                if ((^{shift_q, par_q}) && dat_s2_q) ok_d  = 1'b1;
                else                                err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Stalled partial frame: drop it without flagging an error.
        if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1))
            state_d = IDLE;
    end

    // Decoder runs one cycle after the stop bit; shift_q is stable then.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sc_q  <= '0;
            kv_q  <= 1'b0;
            fe_q  <= 1'b0;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
            w_q   <= 1'b0;
            s_q   <= 1'b0;
            o_q   <= 1'b0;
            l_q   <= 1'b0;
        end else begin
            kv_q <= ok_q;
            fe_q <= err_q;
            if (err_q) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end else if (ok_q) begin
                sc_q <= shift_q;
                if (shift_q == 8'hF0)      brk_q <= 1'b1;
                else if (shift_q == 8'hE0) ext_q <= 1'b1;
                else begin
                    if (!ext_q) begin
                        case (shift_q)
                            8'h1D:   w_q <= ~brk_q;
                            8'h1B:   s_q <= ~brk_q;
                            8'h44:   o_q <= ~brk_q;
                            8'h4B:   l_q <= ~brk_q;
                            default: ;
                        endcase
                    end
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                end
            end
        end
    end

    assign w_in       = w_q;
    assign s_in       = s_q;
    assign o_in       = o_q;
    assign l_in       = l_q;
    assign oSCANCODE  = sc_q;
    assign oKEY_VALID = kv_q;
    assign oFRAME_ERR = fe_q;
endmodule
